alu_muldiv: RTL and testbench

- Iterative multiply/divide unit for the V30MZ core. It covers MUL, IMUL, DIV and IDIV, which the combinational ALU does not.
- Sits beside the ALU in the execute stage. The microcode sequencer starts it with a start/done handshake and stalls while it is busy.
- Parametrised in operand width and bits retired per cycle. Byte and word operation are selected per request.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/alu_muldiv.sv | 204 ++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types for the V30MZ execute stage: combinational ALU opcode and
// flags, plus the iterative multiply/divide opcode and FSM state encodings.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBB, ALU_AND, ALU_OR, ALU_XOR, ALU_CMP,
    ALU_INC, ALU_DEC, ALU_NEG, ALU_NOT
  } AluOp;

  typedef struct packed {
    logic cf;
    logic pf;
    logic af;
    logic zf;
    logic sf;
    logic of;
  } AluFlags;

  typedef enum logic [1:0] {
    MULDIV_MUL  = 2'd0,
    MULDIV_IMUL = 2'd1,
    MULDIV_DIV  = 2'd2,
    MULDIV_IDIV = 2'd3
  } MulDivOp;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_CALC  = 2'd1,
    MD_FIXUP = 2'd2,
    MD_DONE  = 2'd3
  } MulDivState;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply and divide.
//   multiply: LSB-first shift-add; acc += opd when the current multiplier bit
//             is set, multiplier (sh) shifts right, multiplicand (opd) left.
//   divide:   restoring; the next dividend bit is shifted out of sh into the
//             partial remainder, opd (divisor) is trial-subtracted and the
//             quotient bit enters sh from the bottom.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   sh,
  input  logic [2*WIDTH-1:0] opd,
  output logic [2*WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0]   sh_nx,
  output logic [2*WIDTH-1:0] opd_nx
);

  logic [2*WIDTH-1:0] rem_sh;
  logic [2*WIDTH-1:0] diff;
  logic               fits;

  // single iteration, multiply or divide flavour
  always_comb begin
    rem_sh = {acc[2*WIDTH-2:0], sh[WIDTH-1]};
    diff   = rem_sh - opd;
    fits   = (rem_sh >= opd);
    if (is_div) begin
      acc_nx = fits ? diff : rem_sh;
      sh_nx  = {sh[WIDTH-2:0], fits};
      opd_nx = opd;
    end else begin
      acc_nx = acc + (sh[0] ? opd : '0);
      sh_nx  = {1'b0, sh[WIDTH-1:1]};
      opd_nx = {opd[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MUL/IMUL/DIV/IDIV unit beside the ALU. Signed ops run on
// magnitudes; sign correction, flags and IDIV range checks happen in FIXUP.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies leave CALC as soon as
// the unprocessed multiplier bits are all zero (variable latency).
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               size,
  input  logic [2*WIDTH-1:0] a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result_lo,
  output logic [WIDTH-1:0]   result_hi,
  output logic               cy,
  output logic               v,
  output logic               div_error
);

  localparam int W  = WIDTH;
  localparam int H  = WIDTH / 2;
  localparam int S  = STEPS_PER_CYCLE;
  localparam int KW = $clog2(W / S + 1);
  localparam logic [KW-1:0] K_WORD = KW'(W / S - 1);
  localparam logic [KW-1:0] K_BYTE = KW'(H / S - 1);

  MulDivState    state;
  MulDivOp       op_q;
  logic          size_q, sign_q, rsign_q, hi_ovf_q;
  logic [KW-1:0] cnt;
  logic [2*W-1:0] acc, opd;
  logic [W-1:0]   sh;

  MulDivOp op_in;
  logic    is_div_in, signed_in, neg_a, neg_b, neg_d, hi_ovf, div_early;
  logic [W-1:0]   mask_n, a_n, b_n, amag, bmag, dvd_hi, dvd_lo;
  logic [2*W-1:0] mask_2n, a_2n, dmag;

  assign op_in = MulDivOp'(op);
  assign busy  = (state == MD_CALC) || (state == MD_FIXUP);
  assign done  = (state == MD_DONE);

  // request decode: operand masking to the selected size, magnitudes, and
  // the divide exceptions that can be seen before any iteration
  always_comb begin
    is_div_in = op_in[1];
    signed_in = (op_in == MULDIV_IMUL) || (op_in == MULDIV_IDIV);
    mask_n    = size ? '1 : {{H{1'b0}}, {H{1'b1}}};
    mask_2n   = size ? '1 : {{W{1'b0}}, {W{1'b1}}};
    a_n       = a[W-1:0] & mask_n;
    a_2n      = a & mask_2n;
    b_n       = b & mask_n;
    neg_a     = signed_in && (size ? a[W-1]   : a[H-1]);
    neg_d     = signed_in && (size ? a[2*W-1] : a[W-1]);
    neg_b     = signed_in && (size ? b[W-1]   : b[H-1]);
    amag      = neg_a ? ((-a_n) & mask_n)   : a_n;
    dmag      = neg_d ? ((-a_2n) & mask_2n) : a_2n;
    bmag      = neg_b ? ((-b_n) & mask_n)   : b_n;
    // dividend low half is left-aligned so the divide step always pulls
    // from sh[W-1], whatever the size
    dvd_hi    = size ? dmag[2*W-1:W] : {{H{1'b0}}, dmag[W-1:H]};
    dvd_lo    = size ? dmag[W-1:0]   : {dmag[H-1:0], {H{1'b0}}};
    hi_ovf    = (dvd_hi >= bmag);
    div_early = is_div_in && ((b_n == '0) || ((op_in == MULDIV_DIV) && hi_ovf));
  end

  // iteration chain, S radix-2 steps per clock
  logic [S:0][2*W-1:0] acc_c, opd_c;
  logic [S:0][W-1:0]   sh_c;

  assign acc_c[0] = acc;
  assign sh_c[0]  = sh;
  assign opd_c[0] = opd;

  for (genvar i = 0; i < S; i++) begin : g_step
    muldiv_step #(.WIDTH(W)) u_step (
      .is_div (op_q[1]),
      .acc    (acc_c[i]),
      .sh     (sh_c[i]),
      .opd    (opd_c[i]),
      .acc_nx (acc_c[i+1]),
      .sh_nx  (sh_c[i+1]),
      .opd_nx (opd_c[i+1])
    );
  end

  logic mul_zero_in, mul_exit;
`ifdef MULDIV_EARLY_OUT_EN
  assign mul_zero_in = (bmag == '0);
  assign mul_exit    = !op_q[1] && (sh_c[S] == '0);
`else
  assign mul_zero_in = 1'b0;
  assign mul_exit    = 1'b0;
`endif

  // FIXUP: sign correction, flag generation and IDIV range check
  logic [W-1:0]   mask_q, half_q, qmag, rmag, quo, rem, p_top, div_lo, div_hi;
  logic [2*W-1:0] prod;
  logic           p_sbit, mul_ovf, div_ovf;

  always_comb begin
    mask_q  = size_q ? '1 : {{H{1'b0}}, {H{1'b1}}};
    half_q  = size_q ? {1'b1, {(W-1){1'b0}}} : {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};
    prod    = sign_q ? ((-acc) & (size_q ? '1 : {{W{1'b0}}, {W{1'b1}}})) : acc;
    p_top   = size_q ? prod[2*W-1:W] : {{H{1'b0}}, prod[W-1:H]};
    p_sbit  = size_q ? prod[W-1] : prod[H-1];
    mul_ovf = (op_q == MULDIV_IMUL) ? (p_top != (p_sbit ? mask_q : '0))
                                    : (p_top != '0);
    qmag    = sh & mask_q;
    rmag    = acc[W-1:0] & mask_q;
    quo     = sign_q  ? ((-qmag) & mask_q) : qmag;
    rem     = rsign_q ? ((-rmag) & mask_q) : rmag;
    // -2^(n-1) is a legal negative quotient; +2^(n-1) is not
    div_ovf = (op_q == MULDIV_IDIV) &&
              (hi_ovf_q || (sign_q ? (qmag > half_q) : (qmag >= half_q)));
    // byte divide packs remainder:quotient into result_lo, result_hi cleared
    div_lo  = size_q ? quo : {rem[H-1:0], quo[H-1:0]};
    div_hi  = size_q ? rem : '0;
  end

  // control FSM and datapath registers; flush overrides everything but reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= MD_IDLE;
      op_q      <= MULDIV_MUL;
      size_q    <= 1'b0;
      sign_q    <= 1'b0;
      rsign_q   <= 1'b0;
      hi_ovf_q  <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      sh        <= '0;
      opd       <= '0;
      result_lo <= '0;
      result_hi <= '0;
      cy        <= 1'b0;
      v         <= 1'b0;
      div_error <= 1'b0;
    end else if (flush) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          op_q     <= op_in;
          size_q   <= size;
          sign_q   <= is_div_in ? (neg_d ^ neg_b) : (neg_a ^ neg_b);
          rsign_q  <= neg_d;
          hi_ovf_q <= hi_ovf;
          cnt      <= size ? K_WORD : K_BYTE;
          if (is_div_in) begin
            acc <= {{W{1'b0}}, dvd_hi};
            sh  <= dvd_lo;
            opd <= {{W{1'b0}}, bmag};
          end else begin
            acc <= '0;
            sh  <= bmag;
            opd <= {{W{1'b0}}, amag};
          end
          if (div_early) begin
            div_error <= 1'b1;
            state     <= MD_DONE;
          end else if (mul_zero_in && !is_div_in) begin
            state <= MD_FIXUP;
          end else begin
            state <= MD_CALC;
          end
        end
        MD_CALC: begin
          acc <= acc_c[S];
          sh  <= sh_c[S];
          opd <= opd_c[S];
          cnt <= cnt - 1'b1;
          if ((cnt == '0) || mul_exit) state <= MD_FIXUP;
        end
        MD_FIXUP: begin
          state <= MD_DONE;
          if (op_q[1]) begin
            div_error <= div_ovf;
            if (!div_ovf) begin
              result_lo <= div_lo;
              result_hi <= div_hi;
            end
          end else begin
            div_error <= 1'b0;
            result_lo <= prod[W-1:0];
            result_hi <= prod[2*W-1:W];
            cy        <= mul_ovf;
            v         <= mul_ovf;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (WIDTH=16, one step per clock).
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        size = 1'b0;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cy, v, div_error;
  logic [15:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_MUL_B2 = 4;
  localparam int LAT_MUL_W3 = 4;
  localparam int LAT_MUL_B1 = 3;
`else
  localparam int LAT_MUL_B2 = 10;
  localparam int LAT_MUL_W3 = 18;
  localparam int LAT_MUL_B1 = 10;
`endif

  alu_muldiv #(.WIDTH(16), .STEPS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .start     (start),
    .op        (op),
    .size      (size),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .cy        (cy),
    .v         (v),
    .div_error (div_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // issue one request (accepted at cycle T); lat = n where done is seen at T+n
  task automatic run(input logic [1:0] o, input logic s, input logic [31:0] av,
                     input logic [15:0] bv, output int lat);
    @(posedge clk); #1;
    op = o; size = s; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    while (!done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // latency, results and the {cy,v,div_error} flag triple
  task automatic res(input string tag, input int lat, input int exp_lat,
                     input logic [15:0] lo, input logic [15:0] hi, input logic [2:0] fl);
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".lo"}, result_lo, lo);
    chk({tag, ".hi"}, result_hi, hi);
    chk({tag, ".flags"}, {cy, v, div_error}, fl);
  endtask

  int  lat;
  logic seen_done;

  initial begin
    #12;
    chk("rst.ctl", {busy, done, cy, v, div_error}, 5'b0);
    chk("rst.lo", result_lo, 16'h0);
    chk("rst.hi", result_hi, 16'h0);
    @(negedge clk); rst_n = 1'b1;

    // IMUL word: -1 * 3 = -3, high half is pure sign extension
    run(MULDIV_IMUL, 1'b1, 32'h0000_FFFF, 16'h0003, lat);
    res("imul_w", lat, LAT_MUL_W3, 16'hFFFD, 16'hFFFF, 3'b000);

    // MUL byte 0x80*2 = 0x100; junk above the byte operands must be ignored
    run(MULDIV_MUL, 1'b0, 32'h1234_5680, 16'hAA02, lat);
    res("mul_b", lat, LAT_MUL_B2, 16'h0100, 16'h0000, 3'b110);
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);

    // DIV word 0x10005 / 0x10 = 0x1000 r 5; cy/v keep the MUL values
    run(MULDIV_DIV, 1'b1, 32'h0001_0005, 16'h0010, lat);
    res("div_w", lat, 18, 16'h1000, 16'h0005, 3'b110);

    // early exceptions: divide by zero, then byte high half 0x40 >= 1
    run(MULDIV_DIV, 1'b0, 32'h0000_1234, 16'h0000, lat);
    res("div_z", lat, 1, 16'h1000, 16'h0005, 3'b111);
    run(MULDIV_DIV, 1'b0, 32'h0000_4000, 16'h0001, lat);
    res("div_hi", lat, 1, 16'h1000, 16'h0005, 3'b111);

    // IDIV byte -7 / 2 = -3 r -1, remainder follows the dividend
    run(MULDIV_IDIV, 1'b0, 32'h0000_FFF9, 16'h0002, lat);
    chk("idiv_a.lat", lat, 10);
    chk("idiv_a.lo", result_lo, 16'hFFFD);
    chk("idiv_a.de", div_error, 1'b0);

    // 128 / -1 = -128 is representable
    run(MULDIV_IDIV, 1'b0, 32'h0000_0080, 16'h00FF, lat);
    chk("idiv_b.lo", result_lo, 16'h0080);
    chk("idiv_b.de", div_error, 1'b0);

    // -128 / -1 = +128 overflows, caught in FIXUP, result kept
    run(MULDIV_IDIV, 1'b0, 32'h0000_FF80, 16'h00FF, lat);
    chk("idiv_c.lat", lat, 10);
    chk("idiv_c.lo", result_lo, 16'h0080);
    chk("idiv_c.de", div_error, 1'b1);

    // IMUL byte -128 * -1 = +128, does not fit a signed byte
    run(MULDIV_IMUL, 1'b0, 32'h0000_0080, 16'h00FF, lat);
    res("imul_b", lat, LAT_MUL_B1, 16'h0080, 16'h0000, 3'b110);

    // flush and start together in IDLE: start is dropped
    @(posedge clk); #1;
    op = MULDIV_MUL; size = 1'b1; a = 32'h0000_1234; b = 16'h5678;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start.busy", busy, 1'b0);

    // word MUL flushed at T+4, new start at T+5
    @(posedge clk); #1;
    start = 1'b1;
    seen_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fl.busy1", busy, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      seen_done |= done;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    seen_done |= done;
    chk("fl.busy5", busy, 1'b0);
    chk("fl.nodone", seen_done, 1'b0);
    chk("fl.lo", result_lo, 16'h0080);
    op = MULDIV_MUL; size = 1'b1; a = 32'h0000_FFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1;
    chk("fl.restart", busy, 1'b1);
    while (!done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    res("mul_w", lat, 18, 16'h0001, 16'hFFFE, 3'b110);

    // async reset in the middle of CALC clears outputs at once
    @(posedge clk); #1;
    op = MULDIV_DIV; size = 1'b1; a = 32'h0001_0005; b = 16'h0010; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst.ctl", {busy, done, cy, v, div_error}, 5'b0);
    chk("arst.lo", result_lo, 16'h0);
    chk("arst.hi", result_hi, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst.idle", {busy, done}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
